transaction_engine: RTL



---
 rtl/transaction_engine.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/transaction_engine.sv
// transaction_engine: validated balance transfer between two players over a shared synchronous memory port.
// Optional macro TX_FEE_EN burns a per-transaction FEE from the sender.
`default_nettype none

module transaction_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int FEE    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_transaction,
  input  logic              reset_others,
  input  logic              player,
  input  logic [DATA_W-1:0] amount,
  input  logic [DATA_W-1:0] key,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              finished_transaction,
  output logic              tx_ok,
  output logic [1:0]        tx_err
);

  localparam logic [3:0] c_IDLE   = 4'd0;
  localparam logic [3:0] c_KEY_A  = 4'd1;
  localparam logic [3:0] c_KEY_W  = 4'd2;
  localparam logic [3:0] c_SBAL_A = 4'd3;
  localparam logic [3:0] c_SBAL_W = 4'd4;
  localparam logic [3:0] c_RBAL_A = 4'd5;
  localparam logic [3:0] c_RBAL_W = 4'd6;
  localparam logic [3:0] c_CHECK  = 4'd7;
  localparam logic [3:0] c_WR_S   = 4'd8;
  localparam logic [3:0] c_WR_R   = 4'd9;
  localparam logic [3:0] c_DONE   = 4'd10;

  localparam logic [1:0] c_ERR_NONE  = 2'b00;
  localparam logic [1:0] c_ERR_KEY   = 2'b01;
  localparam logic [1:0] c_ERR_FUNDS = 2'b10;
  localparam logic [1:0] c_ERR_OVF   = 2'b11;

`ifdef TX_FEE_EN
  localparam logic [DATA_W:0] c_FEE = (DATA_W+1)'(FEE);
`else
  // Fee disabled: forced to zero while keeping the parameter list uniform.
  localparam logic [DATA_W:0] c_FEE = (DATA_W+1)'(FEE) & '0;
`endif

  logic [3:0]        state_q,  state_d;
  logic              player_q, player_d;
  logic [DATA_W-1:0] amount_q, amount_d;
  logic [DATA_W-1:0] key_q,    key_d;
  logic [DATA_W-1:0] skey_q,   skey_d;
  logic [DATA_W-1:0] sbal_q,   sbal_d;
  logic [DATA_W-1:0] rbal_q,   rbal_d;
  logic              tx_ok_q,  tx_ok_d;
  logic [1:0]        tx_err_q, tx_err_d;

  logic [ADDR_W-1:0] w_skey_addr;
  logic [ADDR_W-1:0] w_sbal_addr;
  logic [ADDR_W-1:0] w_rbal_addr;
  logic [DATA_W:0]   w_need;
  logic [DATA_W:0]   w_rsum;
  logic              w_funds_err;
  logic              w_ovf;
  logic [DATA_W-1:0] w_snew;

  // Balance lives at the even address of a player pair, key at the odd one.
  assign w_skey_addr = {{(ADDR_W-2){1'b0}},  player_q, 1'b1};
  assign w_sbal_addr = {{(ADDR_W-2){1'b0}},  player_q, 1'b0};
  assign w_rbal_addr = {{(ADDR_W-2){1'b0}}, ~player_q, 1'b0};

  assign w_need      = {1'b0, amount_q} + c_FEE;
  assign w_funds_err = w_need > {1'b0, sbal_q};
  assign w_rsum      = {1'b0, rbal_q} + {1'b0, amount_q};
  assign w_ovf       = w_rsum[DATA_W];
  assign w_snew      = sbal_q - w_need[DATA_W-1:0];

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    amount_d = amount_q;
    key_d    = key_q;
    skey_d   = skey_q;
    sbal_d   = sbal_q;
    rbal_d   = rbal_q;
    tx_ok_d  = tx_ok_q;
    tx_err_d = tx_err_q;
    case (state_q)
      c_IDLE: begin
        if (!reset_others) begin
          tx_ok_d  = 1'b0;
          tx_err_d = c_ERR_NONE;
        end
        if (start_transaction) begin
          player_d = player;
          amount_d = amount;
          key_d    = key;
          tx_ok_d  = 1'b0;
          tx_err_d = c_ERR_NONE;
          state_d  = c_KEY_A;
        end
      end
      c_KEY_A:  state_d = c_KEY_W;
      c_KEY_W: begin
        skey_d  = mem_rdata;
        state_d = c_SBAL_A;
      end
      c_SBAL_A: state_d = c_SBAL_W;
      c_SBAL_W: begin
        sbal_d  = mem_rdata;
        state_d = c_RBAL_A;
      end
      c_RBAL_A: state_d = c_RBAL_W;
      c_RBAL_W: begin
        rbal_d  = mem_rdata;
        state_d = c_CHECK;
      end
      c_CHECK: begin
        if (key_q != skey_q) begin
          tx_err_d = c_ERR_KEY;
          state_d  = c_DONE;
        end else if (w_funds_err) begin
          tx_err_d = c_ERR_FUNDS;
          state_d  = c_DONE;
        end else if (w_ovf) begin
          tx_err_d = c_ERR_OVF;
          state_d  = c_DONE;
        end else begin
          state_d  = c_WR_S;
        end
      end
      c_WR_S:   state_d = c_WR_R;
      c_WR_R: begin
        tx_ok_d = 1'b1;
        state_d = c_DONE;
      end
      c_DONE: begin
        if (!reset_others) begin
          tx_ok_d  = 1'b0;
          tx_err_d = c_ERR_NONE;
          state_d  = c_IDLE;
        end else if (!start_transaction) begin
          state_d  = c_IDLE;
        end
      end
      default:  state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= c_IDLE;
      player_q <= 1'b0;
      amount_q <= '0;
      key_q    <= '0;
      skey_q   <= '0;
      sbal_q   <= '0;
      rbal_q   <= '0;
      tx_ok_q  <= 1'b0;
      tx_err_q <= c_ERR_NONE;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      amount_q <= amount_d;
      key_q    <= key_d;
      skey_q   <= skey_d;
      sbal_q   <= sbal_d;
      rbal_q   <= rbal_d;
      tx_ok_q  <= tx_ok_d;
      tx_err_q <= tx_err_d;
    end
  end

  // Moore outputs; the read address is held through each *_W cycle.
  always_comb begin
    mem_address          = '0;
    mem_wdata            = '0;
    mem_wren             = 1'b0;
    finished_transaction = 1'b0;
    case (state_q)
      c_KEY_A, c_KEY_W:   mem_address = w_skey_addr;
      c_SBAL_A, c_SBAL_W: mem_address = w_sbal_addr;
      c_RBAL_A, c_RBAL_W: mem_address = w_rbal_addr;
      c_WR_S: begin
        mem_address = w_sbal_addr;
        mem_wdata   = w_snew;
        mem_wren    = 1'b1;
      end
      c_WR_R: begin
        mem_address = w_rbal_addr;
        mem_wdata   = w_rsum[DATA_W-1:0];
        mem_wren    = 1'b1;
      end
      c_DONE:             finished_transaction = 1'b1;
      default: ;
    endcase
  end

  assign tx_ok  = tx_ok_q;
  assign tx_err = tx_err_q;

endmodule

`default_nettype wire
